// File: rtl/ffd.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : ffd
//  Description : D-type register with clock enable and asynchronous,
//                active-high reset. Retiming and storage cell for a data bit
//                or word that must be held across cycles under enable control.
//
//  Parameters  : WIDTH    - width of dados / saida
//                RST_VAL  - value forced onto saida while rst is high
//
//  Ports       : saida     out  [WIDTH-1:0]  registered data output
//                dados     in   [WIDTH-1:0]  data input
//                clk       in                system clock, rising edge
//                rst       in                asynchronous reset, active-high
//                habilita  in                clock enable, active-high
//
//  Revision    : 1.0  initial release
// ============================================================================
module ffd #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    output logic [WIDTH-1:0] saida,
    input  logic [WIDTH-1:0] dados,
    input  logic             clk,
    input  logic             rst,
    input  logic             habilita
);

    // Reset is in the sensitivity list so saida leaves its stored value as
    // soon as rst rises, without waiting for clk. If rst rises in the same
    // instant as clk, the reset branch still has priority. Release is not
    // synchronised here; a synchroniser upstream handles that if needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saida <= RST_VAL;
        end else if (habilita) begin
            saida <= dados;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ffd.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ffd
//  Description : Directed, self-checking bench for ffd. Runs a 1-bit instance
//                with default reset value and an 8-bit instance with a
//                non-zero reset value, sharing clk, rst and habilita.
//                Clock period 40 ns, first rising edge at t=20; outputs are
//                sampled 7 ns after edges or between edges for async checks.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ffd;

    localparam logic [7:0] c_rst_val_w = 8'hA5;

    logic       clk;
    logic       rst;
    logic       habilita;
    logic       dados;
    logic       saida;
    logic [7:0] dados_w;
    logic [7:0] saida_w;

    int n_tests = 0;
    int n_fail  = 0;

    ffd u_dut (
        .saida    (saida),
        .dados    (dados),
        .clk      (clk),
        .rst      (rst),
        .habilita (habilita)
    );

    ffd #(
        .WIDTH   (8),
        .RST_VAL (c_rst_val_w)
    ) u_dut_w (
        .saida    (saida_w),
        .dados    (dados_w),
        .clk      (clk),
        .rst      (rst),
        .habilita (habilita)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] got,
                               input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Advance to an absolute simulation time in ns.
    task automatic go(input int t);
        #(t - int'($time));
    endtask

    initial begin
        rst      = 1'b1;
        habilita = 1'b0;
        dados    = 1'b0;
        dados_w  = 8'h00;

        // Reset hold, including across the edge at t=20
        go(5);
        check_value("rst_hold_a",   {7'd0, saida}, 8'h00);
        check_value("rst_hold_a_w", saida_w, c_rst_val_w);
        go(27);
        check_value("rst_hold_b",   {7'd0, saida}, 8'h00);
        check_value("rst_hold_b_w", saida_w, c_rst_val_w);

        go(33);  rst      = 1'b0;
        go(43);  habilita = 1'b1;
        go(47);  dados = 1'b1; dados_w = 8'h3C;
        // No edge since the data change: nothing captured yet
        go(50);
        check_value("no_edge",   {7'd0, saida}, 8'h00);
        check_value("no_edge_w", saida_w, c_rst_val_w);

        // Capture at t=60, still held after t=100
        go(67);
        check_value("capture",   {7'd0, saida}, 8'h01);
        check_value("capture_w", saida_w, 8'h3C);
        go(107);
        check_value("capture_keep", {7'd0, saida}, 8'h01);

        // Falling capture at t=140
        go(120); dados = 1'b0; dados_w = 8'hC3;
        go(147);
        check_value("fall",   {7'd0, saida}, 8'h00);
        check_value("fall_w", saida_w, 8'hC3);

        // Rising again at t=220
        go(213); dados = 1'b1;
        go(227);
        check_value("rise_again", {7'd0, saida}, 8'h01);

        // Inter-edge glitch: 13 ns pulse between edges 300 and 340
        go(278); dados = 1'b0;
        go(307);
        check_value("glitch_pre", {7'd0, saida}, 8'h00);
        go(321); dados = 1'b1;
        go(334); dados = 1'b0;
        go(347);
        check_value("glitch_rej", {7'd0, saida}, 8'h00);

        // Load 1 / FF at t=380, then hold with enable off
        go(350); dados = 1'b1; dados_w = 8'hFF;
        go(387);
        check_value("load_one",   {7'd0, saida}, 8'h01);
        check_value("load_one_w", saida_w, 8'hFF);
        go(390); habilita = 1'b0; dados = 1'b0; dados_w = 8'h00;
        go(427);
        check_value("hold_a",   {7'd0, saida}, 8'h01);
        check_value("hold_a_w", saida_w, 8'hFF);
        go(430); dados = 1'b1;
        go(440); dados = 1'b0;
        go(467);
        check_value("hold_b", {7'd0, saida}, 8'h01);

        // Async reset mid-cycle: output changes before the edge at t=500
        go(470); rst = 1'b1;
        go(471);
        check_value("async_rst",   {7'd0, saida}, 8'h00);
        check_value("async_rst_w", saida_w, c_rst_val_w);

        // Reset dominates an enabled edge with new data
        go(475); habilita = 1'b1; dados = 1'b1; dados_w = 8'h81;
        go(507);
        check_value("rst_dominates",   {7'd0, saida}, 8'h00);
        check_value("rst_dominates_w", saida_w, c_rst_val_w);

        // Release; first enabled edge at t=540 captures
        go(510); rst = 1'b0;
        go(547);
        check_value("post_rst_cap",   {7'd0, saida}, 8'h01);
        check_value("post_rst_cap_w", saida_w, 8'h81);

        // Enable pulse entirely between edges has no effect
        go(550); habilita = 1'b0; dados = 1'b0; dados_w = 8'h18;
        go(560); habilita = 1'b1;
        go(570); habilita = 1'b0;
        go(587);
        check_value("en_glitch",   {7'd0, saida}, 8'h01);
        check_value("en_glitch_w", saida_w, 8'h81);

        // Reset asserted on the same instant as an enabled edge
        go(600); habilita = 1'b1; dados = 1'b1; dados_w = 8'h18;
        go(620); rst = 1'b1;
        go(627);
        check_value("rst_at_edge",   {7'd0, saida}, 8'h00);
        check_value("rst_at_edge_w", saida_w, c_rst_val_w);

        go(633); rst = 1'b0;
        go(667);
        check_value("final_cap_w", saida_w, 8'h18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
